// File: rtl/frame_scan_controller_if.sv
// Signal bundle between the frame scan controller and its surroundings:
// start/abort control, scan counter, frame buffer read port and Avalon-ST source.
interface frame_scan_controller_if #(
    parameter int X_W    = 2,
    parameter int Y_W    = 2,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic              cnt_clear;
    logic              cnt_inc;
    logic [X_W-1:0]    cnt_x;
    logic [Y_W-1:0]    cnt_y;
    logic              cnt_finished;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] src_data;
    logic              src_valid;
    logic              src_ready;
    logic              src_sop;
    logic              src_eop;

    modport master (
        input  start, abort, cnt_x, cnt_y, cnt_finished, rd_data, src_ready,
        output busy, done, cnt_clear, cnt_inc, rd_en, rd_addr,
               src_data, src_valid, src_sop, src_eop
    );

    modport slave (
        output start, abort, cnt_x, cnt_y, cnt_finished, rd_data, src_ready,
        input  busy, done, cnt_clear, cnt_inc, rd_en, rd_addr,
               src_data, src_valid, src_sop, src_eop
    );
endinterface

// File: rtl/frame_scan_controller.sv
// Walks an external X/Y scan counter over one stored frame, reads each pixel from
// the frame buffer and streams it out as one Avalon-ST packet with backpressure.
module frame_scan_controller #(
    parameter int X_END  = 3,
    parameter int Y_END  = 3,
    parameter int X_W    = 2,
    parameter int Y_W    = 2,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input logic clk,
    input logic rst,
    frame_scan_controller_if.master bus
);
    if ((X_END + 1) * (Y_END + 1) > (1 << ADDR_W)) begin : g_frame_fits
        $error("frame_scan_controller: frame does not fit the read address range");
    end

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

    state_t            state;
    logic              busy_q;
    logic              done_q;
    logic              clear_q;

    logic              in_flight;
    logic              in_flight_sop;
    logic              in_flight_eop;
    logic [DATA_W-1:0] fifo_data [2];
    logic [1:0]        fifo_sop;
    logic [1:0]        fifo_eop;
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        count;

    logic              abort_act;
    logic              valid;
    logic              pop;
    logic              push;
    logic              issue;
    logic [2:0]        occupancy;
    logic [DATA_W-1:0] head_data;
    logic              head_sop;
    logic              head_eop;
    logic [ADDR_W-1:0] scan_addr;

    // A read may go out only if the buffer can still absorb it once every
    // stored and in-flight pixel, minus the beat leaving now, is accounted for.
    always_comb begin
        abort_act = bus.abort && (state != IDLE);
        valid     = (count != 2'd0);
        pop       = valid && bus.src_ready;
        occupancy = 3'(count) + 3'(in_flight) - 3'(pop);
        issue     = (state == RUN) && !abort_act && (occupancy < 3'd2);
        push      = in_flight && !abort_act;
        head_data = fifo_data[rd_ptr];
        head_sop  = fifo_sop[rd_ptr];
        head_eop  = fifo_eop[rd_ptr];
        scan_addr = ADDR_W'(32'(bus.cnt_x) * 32'(Y_END + 1) + 32'(bus.cnt_y));
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.cnt_clear = clear_q;
    assign bus.cnt_inc   = issue;
    assign bus.rd_en     = issue;
    assign bus.rd_addr   = issue ? scan_addr : '0;
    assign bus.src_valid = valid;
    assign bus.src_data  = valid ? head_data : '0;
    assign bus.src_sop   = valid && head_sop;
    assign bus.src_eop   = valid && head_eop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count         <= 2'd0;
            rd_ptr        <= 1'b0;
            wr_ptr        <= 1'b0;
            fifo_sop      <= 2'b00;
            fifo_eop      <= 2'b00;
            in_flight     <= 1'b0;
            in_flight_sop <= 1'b0;
            in_flight_eop <= 1'b0;
        end else if (abort_act) begin
            count     <= 2'd0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            in_flight <= 1'b0;
        end else begin
            in_flight <= issue;
            if (issue) begin
                in_flight_sop <= (bus.cnt_x == '0) && (bus.cnt_y == '0);
                in_flight_eop <= bus.cnt_finished;
            end
            if (push) begin
                fifo_sop[wr_ptr] <= in_flight_sop;
                fifo_eop[wr_ptr] <= in_flight_eop;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= bus.rd_data;
        end
    end

    // The EOP pixel is the final read, so once it is accepted the buffer is
    // empty and nothing is in flight: that beat alone ends the drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            clear_q <= 1'b0;
            if (abort_act) begin
                state   <= IDLE;
                busy_q  <= 1'b0;
                clear_q <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            state   <= CLEAR;
                            busy_q  <= 1'b1;
                            clear_q <= 1'b1;
                        end
                    end
                    CLEAR: state <= RUN;
                    RUN: begin
                        if (issue && bus.cnt_finished) begin
                            state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (pop && head_eop) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                    DONE: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                    default: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_frame_scan_controller.sv
// Self-checking bench: models the external scan counter and frame buffer, drives
// random frames and ready patterns, and scores every read and beat against raster order.
module tb_frame_scan_controller;
    localparam int X_END  = 3;
    localparam int Y_END  = 3;
    localparam int X_W    = 2;
    localparam int Y_W    = 2;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int PIXELS = (X_END + 1) * (Y_END + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    frame_scan_controller_if #(.X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    frame_scan_controller_if #(.X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_one ();

    frame_scan_controller #(
        .X_END(X_END), .Y_END(Y_END), .X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    frame_scan_controller #(
        .X_END(0), .Y_END(0), .X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut_one (.clk(clk), .rst(rst), .bus(bus_one));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cyc = 0;
    int read_idx = 0, beat_idx = 0, done_count = 0, done_cyc = -1, clear_cyc = -1;
    int busy_count = 0, busy_first = -1, busy_last = -1;
    bit timing_mode = 1'b0;
    int ready_mode = 0;
    int phase = 0;
    bit pattern_bits [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    logic prev_sop = 1'b0, prev_eop = 1'b0;
    logic [DATA_W-1:0] fb [PIXELS];
    logic [DATA_W-1:0] rd_data_a = '0;
    logic [DATA_W-1:0] fb_one = '0;
    logic [DATA_W-1:0] rd_data_one = '0;
    logic [X_W-1:0] scan_x;
    logic [Y_W-1:0] scan_y;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference scan counter: row-major walk that wraps to (0,0) after the last pixel.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_x <= '0;
            scan_y <= '0;
        end else if (bus.cnt_clear) begin
            scan_x <= '0;
            scan_y <= '0;
        end else if (bus.cnt_inc) begin
            if (scan_y == Y_W'(Y_END)) begin
                scan_y <= '0;
                scan_x <= (scan_x == X_W'(X_END)) ? '0 : scan_x + 1'b1;
            end else begin
                scan_y <= scan_y + 1'b1;
            end
        end
    end

    assign bus.cnt_x        = scan_x;
    assign bus.cnt_y        = scan_y;
    assign bus.cnt_finished = (scan_x == X_W'(X_END)) && (scan_y == Y_W'(Y_END));
    assign bus.rd_data      = rd_data_a;

    always @(posedge clk) if (bus.rd_en) rd_data_a <= fb[bus.rd_addr];

    assign bus_one.cnt_x        = '0;
    assign bus_one.cnt_y        = '0;
    assign bus_one.cnt_finished = 1'b1;
    assign bus_one.rd_data      = rd_data_one;

    always @(posedge clk) if (bus_one.rd_en) rd_data_one <= fb_one;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
        case (ready_mode)
            0: bus.src_ready = 1'b1;
            1: begin
                bus.src_ready = pattern_bits[phase % 4];
                phase++;
            end
            2: bus.src_ready = 1'($urandom_range(0, 1));
            default: bus.src_ready = 1'b0;
        endcase
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) stepCycle();
    endtask

    task automatic waitDone(input int limit);
        int n = 0;
        while (done_count == 0 && n < limit) begin
            stepCycle();
            n++;
        end
        if (done_count == 0) checkOutput("doneTimeout", 0, 1);
    endtask

    // Fresh random frame contents, cleared scoreboard, one-cycle start pulse in cycle 0.
    task automatic applyStimulus();
        for (int i = 0; i < PIXELS; i++) fb[i] = DATA_W'($urandom);
        read_idx = 0; beat_idx = 0; done_count = 0; done_cyc = -1; clear_cyc = -1;
        busy_count = 0; busy_first = -1; busy_last = -1; phase = 0;
        bus.start = 1'b1;
        start_cyc = cyc;
        stepCycle();
        bus.start = 1'b0;
    endtask

    initial begin : monitor
        int rel;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                rel = cyc - start_cyc;
                if (prev_stall) begin
                    checkOutput("stallValid", 32'(bus.src_valid), 1);
                    checkOutput("stallData", 32'(bus.src_data), 32'(prev_data));
                    checkOutput("stallSop", 32'(bus.src_sop), 32'(prev_sop));
                    checkOutput("stallEop", 32'(bus.src_eop), 32'(prev_eop));
                end
                if (bus.cnt_clear) clear_cyc = rel;
                if (bus.busy) begin
                    busy_count++;
                    if (busy_first < 0) busy_first = rel;
                    busy_last = rel;
                end
                if (bus.rd_en) begin
                    checkOutput("rdAddr", 32'(bus.rd_addr), read_idx % PIXELS);
                    if (timing_mode) checkOutput("rdCycle", rel, 2 + read_idx);
                    read_idx++;
                end
                if (bus.src_valid && bus.src_ready && !bus.abort) begin
                    checkOutput("beatData", 32'(bus.src_data), 32'(fb[beat_idx % PIXELS]));
                    checkOutput("beatSop", 32'(bus.src_sop), 32'(beat_idx == 0));
                    checkOutput("beatEop", 32'(bus.src_eop), 32'(beat_idx == PIXELS - 1));
                    if (timing_mode) checkOutput("beatCycle", rel, 4 + beat_idx);
                    beat_idx++;
                end
                if (bus.busy) checkOutput("outstanding", 32'((read_idx - beat_idx) <= 2), 1);
                if (bus.done) begin
                    done_count++;
                    done_cyc = rel;
                end
                prev_stall = bus.src_valid && !bus.src_ready && !bus.abort;
                prev_data  = bus.src_data;
                prev_sop   = bus.src_sop;
                prev_eop   = bus.src_eop;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin : main
        int one_reads, one_beats, one_done, beat_at, done_at;
        bus.start = 1'b0; bus.abort = 1'b0; bus.src_ready = 1'b0;
        bus_one.start = 1'b0; bus_one.abort = 1'b0; bus_one.src_ready = 1'b1;
        rst = 1'b1;
        waitCycles(3);
        checkOutput("rstBusy", 32'(bus.busy), 0);
        checkOutput("rstDone", 32'(bus.done), 0);
        checkOutput("rstClear", 32'(bus.cnt_clear), 0);
        checkOutput("rstRdEn", 32'(bus.rd_en), 0);
        checkOutput("rstValid", 32'(bus.src_valid), 0);
        checkOutput("rstData", 32'(bus.src_data), 0);
        checkOutput("rstSopEop", 32'({bus.src_sop, bus.src_eop}), 0);
        checkOutput("rstOneValid", 32'(bus_one.src_valid), 0);
        rst = 1'b0;
        waitCycles(3);

        $display("[TB] full frame, ready held high");
        ready_mode = 0; timing_mode = 1'b1;
        applyStimulus();
        waitCycles(25);
        checkOutput("fullBeats", beat_idx, PIXELS);
        checkOutput("fullReads", read_idx, PIXELS);
        checkOutput("fullDoneCount", done_count, 1);
        checkOutput("fullDoneCycle", done_cyc, 20);
        checkOutput("fullClearCycle", clear_cyc, 1);
        checkOutput("fullBusyFirst", busy_first, 1);
        checkOutput("fullBusyLast", busy_last, 20);
        checkOutput("fullBusyCount", busy_count, 20);

        $display("[TB] backpressure pattern 1,0,0,1");
        ready_mode = 1; timing_mode = 1'b0;
        applyStimulus();
        waitDone(300);
        waitCycles(5);
        checkOutput("bpBeats", beat_idx, PIXELS);
        checkOutput("bpDoneCount", done_count, 1);
        checkOutput("bpBusy", 32'(bus.busy), 0);

        $display("[TB] random ready");
        ready_mode = 2;
        for (int f = 0; f < 2; f++) begin
            applyStimulus();
            waitDone(400);
            waitCycles(4);
            checkOutput("rndBeats", beat_idx, PIXELS);
            checkOutput("rndDoneCount", done_count, 1);
        end

        $display("[TB] abort after five beats");
        ready_mode = 0; timing_mode = 1'b1;
        waitCycles(2);
        applyStimulus();
        for (int n = 0; n < 50 && beat_idx < 5; n++) stepCycle();
        bus.abort = 1'b1;
        stepCycle();
        bus.abort = 1'b0;
        checkOutput("abortClear", 32'(bus.cnt_clear), 1);
        checkOutput("abortBusy", 32'(bus.busy), 0);
        checkOutput("abortValid", 32'(bus.src_valid), 0);
        checkOutput("abortDone", 32'(bus.done), 0);
        waitCycles(10);
        checkOutput("abortBeats", beat_idx, 5);
        checkOutput("abortReads", read_idx, 7);
        checkOutput("abortNoDone", done_count, 0);
        applyStimulus();
        waitCycles(25);
        checkOutput("restartBeats", beat_idx, PIXELS);
        checkOutput("restartDoneCycle", done_cyc, 20);
        checkOutput("restartDoneCount", done_count, 1);

        $display("[TB] start pulsed while busy");
        applyStimulus();
        waitCycles(5);
        bus.start = 1'b1;
        stepCycle();
        bus.start = 1'b0;
        waitCycles(25);
        checkOutput("ignBeats", beat_idx, PIXELS);
        checkOutput("ignReads", read_idx, PIXELS);
        checkOutput("ignDoneCount", done_count, 1);
        checkOutput("ignBusy", 32'(bus.busy), 0);

        $display("[TB] reset during drain");
        timing_mode = 1'b0;
        applyStimulus();
        for (int n = 0; n < 60 && read_idx < PIXELS; n++) stepCycle();
        checkOutput("drainReads", read_idx, PIXELS);
        ready_mode = 3;
        waitCycles(3);
        checkOutput("drainValid", 32'(bus.src_valid), 1);
        checkOutput("drainBusy", 32'(bus.busy), 1);
        rst = 1'b1;
        #1;
        checkOutput("midRstValid", 32'(bus.src_valid), 0);
        checkOutput("midRstBusy", 32'(bus.busy), 0);
        checkOutput("midRstDone", 32'(bus.done), 0);
        checkOutput("midRstRdEn", 32'(bus.rd_en), 0);
        waitCycles(2);
        rst = 1'b0;
        ready_mode = 0; timing_mode = 1'b1;
        waitCycles(2);
        applyStimulus();
        waitCycles(25);
        checkOutput("postRstBeats", beat_idx, PIXELS);
        checkOutput("postRstDoneCycle", done_cyc, 20);
        checkOutput("postRstDoneCount", done_count, 1);

        $display("[TB] single pixel frame");
        fb_one = DATA_W'($urandom);
        one_reads = 0; one_beats = 0; one_done = 0; beat_at = -1; done_at = -1;
        bus_one.start = 1'b1;
        stepCycle();
        bus_one.start = 1'b0;
        for (int i = 1; i < 12; i++) begin
            if (bus_one.rd_en) begin
                one_reads++;
                checkOutput("oneAddr", 32'(bus_one.rd_addr), 0);
            end
            if (bus_one.src_valid && bus_one.src_ready) begin
                one_beats++;
                beat_at = i;
                checkOutput("oneData", 32'(bus_one.src_data), 32'(fb_one));
                checkOutput("oneSopEop", 32'({bus_one.src_sop, bus_one.src_eop}), 32'b11);
            end
            if (bus_one.done) begin
                one_done++;
                done_at = i;
            end
            stepCycle();
        end
        checkOutput("oneReads", one_reads, 1);
        checkOutput("oneBeats", one_beats, 1);
        checkOutput("oneBeatCycle", beat_at, 4);
        checkOutput("oneDoneCount", one_done, 1);
        checkOutput("oneDoneAfterBeat", done_at, beat_at + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
